// File: rtl/gpio_cond_pkg.sv
// Shared constants and types for the GPIO input conditioning stage
// that sits between the pads and the Microwatt gpio_in bus.
package gpio_cond_pkg;

    localparam int unsigned GPIO_COND_WIDTH     = 29;
    localparam int unsigned DEFAULT_FILT_THRESH = 8;
    localparam int unsigned GPIO_COND_PAD_LSB   = 15;
    localparam int unsigned GPIO_COND_PAD_MSB   = GPIO_COND_PAD_LSB + GPIO_COND_WIDTH - 1;

    typedef enum logic {
        FILT_BYPASS = 1'b0,
        FILT_ACTIVE = 1'b1
    } filt_mode_e;

    // Position of conditioned pin i on the core's gpio_in bus.
    function automatic int unsigned pad_index(input int unsigned pin);
        return GPIO_COND_PAD_LSB + pin;
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin conditioning: two-flop synchronizer, saturating glitch filter
// and rise/fall detection on the filtered level.
module gpio_pin_filter
    import gpio_cond_pkg::*;
#(
    parameter int unsigned FILT_THRESH = DEFAULT_FILT_THRESH,
    parameter int unsigned CNT_W       = $clog2(FILT_THRESH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    input  logic filt_en,
    output logic level,
    output logic rise,
    output logic fall
);

    logic             s1;
    logic             s2;
    logic             filt_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt;
    filt_mode_e       mode;

    always_comb begin
        mode = filt_en ? FILT_ACTIVE : FILT_BYPASS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt_q <= 1'b0;
            prev_q <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= pad;
            s2     <= s1;
            prev_q <= filt_q;
            case (mode)
                FILT_BYPASS: begin
                    filt_q <= s2;
                    cnt    <= '0;
                end
                FILT_ACTIVE: begin
                    // Counter only advances while s2 disagrees, and clears on the flip,
                    // so it never exceeds FILT_THRESH-1 and cannot wrap.
                    if (s2 == filt_q) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(FILT_THRESH - 1)) begin
                        filt_q <= ~filt_q;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    filt_q <= s2;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign level = filt_q;
    assign rise  = filt_q & ~prev_q;
    assign fall  = ~filt_q & prev_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-pin filters plus sticky edge-pending bits
// with write-1-to-clear acknowledge and a registered interrupt request.
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int unsigned WIDTH       = GPIO_COND_WIDTH,
    parameter int unsigned FILT_THRESH = DEFAULT_FILT_THRESH,
    parameter int unsigned CNT_W       = $clog2(FILT_THRESH + 1)
) (
    input  logic             ext_clk,
    input  logic             ext_rst_n,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] filt_en,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_ack,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_filter #(
            .FILT_THRESH(FILT_THRESH),
            .CNT_W      (CNT_W)
        ) u_pin (
            .clk    (ext_clk),
            .rst_n  (ext_rst_n),
            .pad    (pad_in[i]),
            .filt_en(filt_en[i]),
            .level  (level_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // A new enabled edge overrides a same-cycle ack; disabled edges are dropped.
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~irq_ack) | (rise & rise_en) | (fall & fall_en);
            irq     <= |pending;
        end
    end

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input conditioning stage between the 29 general-purpose input pads (gpio_in[43:15]) and the Microwatt GPIO input bus. Each pin gets a two-flop synchronizer, an optional per-pin glitch filter, and rising/falling edge detection. Detected edges latch into sticky pending bits that are acknowledged per pin, and a single interrupt request is produced for the core. The cleaned levels replace the raw pad bits on the core's gpio_in.

## Interface
- WIDTH, 29: number of conditioned pins.
- FILT_THRESH, 8: consecutive disagreeing samples required before the filtered level flips; legal range 1..255.
- CNT_W, $clog2(FILT_THRESH+1): filter counter width (derived; not overridden).

Ports:
- ext_clk  in  1  single clock; all state is on its rising edge.
- ext_rst_n  in  1  asynchronous, active-low reset.
- pad_in  in  WIDTH  raw pad levels; asynchronous to ext_clk.
- filt_en  in  WIDTH  per-pin filter enable; quasi-static.
- rise_en  in  WIDTH  per-pin rising-edge capture enable.
- fall_en  in  WIDTH  per-pin falling-edge capture enable.
- irq_ack  in  WIDTH  write-1-to-clear pulses for the pending bits.
- level_out  out  WIDTH  conditioned level, drives the core's gpio_in.
- pending  out  WIDTH  sticky edge-pending bits.
- irq  out  1  registered OR of pending.

## Operation
- Reset: all synchronizer flops, filt_q, prev_q, counters, pending and irq are cleared to 0.
- Synchronizer: the chain is s1 <= pad_in, then s2 <= s1.
- Filter bypass (filt_en[i]=0):
  - filt_q[i] <= s2[i].
  - cnt[i] is held at 0.
- Filter active (filt_en[i]=1):
  - If s2[i]==filt_q[i], cnt[i] <= 0.
  - Otherwise, if cnt[i]==FILT_THRESH-1, filt_q[i] is toggled and cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - The counter never wraps.
- Changing filt_en mid-count: when filt_en falls, cnt clears and filt_q follows s2 on the next edge. When filt_en rises, counting starts from 0.
- level_out = filt_q.
- Edge detection:
  - prev_q <= filt_q.
  - rise = filt_q & ~prev_q.
  - fall = ~filt_q & prev_q.
- Pending update: pending[i] <= (pending[i] & ~irq_ack[i]) | (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]).
- Simultaneous ack and new edge on the same pin: set wins and pending stays 1.
- An edge whose enable is low is discarded; it is not latched for later.
- irq <= |pending, i.e. one cycle after pending changes.
- A pad held high through reset release produces a rising event 3 cycles after release (bypass) if rise_en is set. Software acks it. This behaviour is intentional.

## Timing
- Bypass, pad change sampled at edge 0:
  - s1 at edge 1, s2 at edge 2.
  - level_out changes at edge 3.
  - pending at edge 4, irq at edge 5.
- Filter active: level_out changes at edge 2+FILT_THRESH, provided s2 disagrees for FILT_THRESH consecutive samples. FILT_THRESH=1 gives the same latency as bypass.
- Glitches with s2 width < FILT_THRESH cycles never reach level_out.
- irq_ack takes effect on the next edge. irq deasserts one edge after the last pending bit clears.
- No combinational path from any input to any output.

## Structure
- Sub-module gpio_pin_filter: one instance per pin, generated WIDTH times. It contains the synchronizer, counter, filt_q and prev_q, and outputs level, rise and fall.
- The top level holds the pending vector, the ack/set logic and the irq register.
- Shared package gpio_cond_pkg:
  - GPIO_COND_WIDTH = 29.
  - DEFAULT_FILT_THRESH = 8.
  - The bit offset 15 of the first conditioned pad.
- The wrapper uses gpio_cond_pkg to map pad_in to gpio_in[43:15].

## Test plan
- Reset release with pad_in=0:
  - Outputs stay 0.
  - Set pin 0 high with filt_en=0 and rise_en=1.
  - Expect level_out[0]=1 at edge 3, pending[0]=1 at edge 4, irq=1 at edge 5.
- Filter on pin 5, FILT_THRESH=8:
  - A 7-cycle high pulse leaves level_out[5]=0 and pending 0.
  - A 9-cycle pulse raises level_out[5] at edge 10 after the start.
- Edge on pin 3 in the same cycle irq_ack[3] clears it: pending[3] stays 1.
- A subsequent ack with no edge clears pending[3]; irq drops one cycle later.
- fall_en=1, rise_en=0 on pin 28:
  - A pulse 0→1→0 sets pending[28] only on the falling transition.
  - Pin 27 with both enables off never sets pending.
- Reset mid-filter:
  - With cnt[2]=5, assert ext_rst_n=0 asynchronously.
  - All outputs are 0 immediately. After release the counter restarts from 0.
- filt_en dropped mid-count on pin 10: level_out[10] follows s2 on the next edge.
